piso_serializer: RTL

- Parallel-in serial-out stage directly downstream of the 4-bit PIPO register.
- Accepts the PIPO's registered word through a valid/ready handshake.
- Shifts the word out one bit per transfer on a valid/ready serial interface, with a last-bit marker and a completed-word counter.
- Supports back-to-back words with no idle cycle between them.

---
 rtl/piso_serializer.sv | 105 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over a valid/ready load port
// and streams it one bit per serial transfer, supporting back-to-back words.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         word_cnt_q, word_cnt_d;

  logic             out_bit;
  logic [WIDTH-1:0] shifted;
  logic             load_fire;
  logic             xfer;
  logic             last_xfer;

  // The output end of the shift register depends on bit order; zeros fill in behind.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit = shift_q[WIDTH-1];
      assign shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit = shift_q[0];
      assign shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    xfer       = ser_valid & ser_ready;
    last_xfer  = xfer & ser_last;
    load_fire  = load_valid & load_ready;
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q + 8'(last_xfer);

    case (state_q)
      IDLE: begin
        if (load_fire) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_xfer) state_d = load_fire ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load can only coincide with a transfer on the last bit, so it wins.
    if (load_fire) begin
      shift_d   = d_in;
      bit_cnt_d = CNT_TOP;
    end else if (xfer) begin
      shift_d   = shifted;
      bit_cnt_d = bit_cnt_q - CNT_W'(1);
    end
  end

  // Output logic; load_ready in SHIFT follows ser_ready combinationally to avoid a bubble.
  always_comb begin
    ser_valid  = (state_q == SHIFT);
    busy       = ser_valid;
    ser_last   = ser_valid && (bit_cnt_q == '0);
    ser_out    = ser_valid ? out_bit : 1'b0;
    load_ready = rst_ && ((state_q == IDLE) || (ser_last && ser_ready));
    word_cnt   = word_cnt_q;
  end

endmodule
